nn_param_loader: RTL and testbench

Parametrised stream-driven loader that fills the network's activation LUT, layer-1 weight SRAM banks and layer-2 weight SRAM banks from one valid/ready word stream. It replaces hand-sequenced en/we/active_we/addr/wdata driving with a hardware sequencer. It sits between the host/DMA stream and the Top memory write ports. It adds a phase-select mask, abort, backpressure and completion signalling.

---
 rtl/nn_load_pkg.sv | 37 +++
 rtl/nn_param_loader_bank_word_counter.sv | 46 ++++
 rtl/nn_param_loader.sv | 158 +++++++++++++++
 tb/tb_nn_param_loader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_load_pkg.sv
// Shared types and helpers for the stream-driven parameter loader:
// sequencer state encoding, phase-mask bit positions and counter sizing.
package nn_load_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LUT_KEY,
        LUT_VAL,
        L1,
        L2,
        DONE
    } state_t;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 18;

    localparam int MASK_LUT = 0;
    localparam int MASK_L1  = 1;
    localparam int MASK_L2  = 2;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First enabled phase strictly after cur, in the fixed order LUT, L1, L2.
    function automatic state_t next_phase(input logic [2:0] mask, input state_t cur);
        if (cur == IDLE && mask[MASK_LUT])
            return LUT_KEY;
        if ((cur == IDLE || cur == LUT_VAL) && mask[MASK_L1])
            return L1;
        if (cur != L2 && mask[MASK_L2])
            return L2;
        return DONE;
    endfunction

endpackage

// File: rtl/nn_param_loader_bank_word_counter.sv
// Two-level address walker: word is the inner loop, bank the outer loop.
// Both wrap to zero after the last (bank, word) pair.
module bank_word_counter
    import nn_load_pkg::*;
#(
    parameter int BANKS = 784,
    parameter int DEPTH = 200
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      inc,
    input  logic                      clr,
    output logic [cnt_w(BANKS)-1:0]   bank,
    output logic [cnt_w(DEPTH)-1:0]   word,
    output logic                      last
);

    localparam int BW = cnt_w(BANKS);
    localparam int WW = cnt_w(DEPTH);

    logic word_last;
    logic bank_last;

    assign word_last = (word == WW'(DEPTH - 1));
    assign bank_last = (bank == BW'(BANKS - 1));
    assign last      = word_last && bank_last;

    // NOTE: non-blocking assignments for every register so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank <= '0;
            word <= '0;
        end else if (clr) begin
            bank <= '0;
            word <= '0;
        end else if (inc) begin
            if (word_last) begin
                word <= '0;
                bank <= bank_last ? '0 : bank + 1'b1;
            end else begin
                word <= word + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nn_param_loader.sv
// Sequencer that turns one valid/ready word stream into LUT and per-bank
// weight SRAM write strobes, with phase mask, abort and completion pulse.
module nn_param_loader
    import nn_load_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int LUT_DEPTH = 121,
    parameter int L1_BANKS  = 784,
    parameter int L1_DEPTH  = 200,
    parameter int L2_BANKS  = 10,
    parameter int L2_DEPTH  = 200
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [2:0]                   load_mask,
    input  logic                         abort,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [DATA_W-1:0]            s_data,
    output logic [1:0]                   en,
    output logic [L1_BANKS+L2_BANKS-1:0] we,
    output logic                         active_we,
    output logic [ADDR_W-1:0]            addr,
    output logic [DATA_W-1:0]            wdata,
    output logic                         busy,
    output logic                         done
);

    localparam int WE_W      = L1_BANKS + L2_BANKS;
    localparam int LW        = cnt_w(LUT_DEPTH);
    localparam int MAX_DEPTH = (L1_DEPTH > L2_DEPTH) ? L1_DEPTH : L2_DEPTH;
    localparam logic [WE_W-1:0] WE_ONE = WE_W'(1);

    if (ADDR_W < cnt_w(MAX_DEPTH)) begin : g_addr_too_narrow
        $error("nn_param_loader: ADDR_W cannot hold the largest bank word index");
    end

    state_t                      state;
    state_t                      nxt;
    logic [2:0]                  mask_reg;
    logic [DATA_W-1:0]           key_reg;
    logic [LW-1:0]               lut_cnt;
    logic                        lut_last;
    logic                        beat;

    logic [cnt_w(L1_BANKS)-1:0]  l1_bank;
    logic [cnt_w(L1_DEPTH)-1:0]  l1_word;
    logic                        l1_last;
    logic [cnt_w(L2_BANKS)-1:0]  l2_bank;
    logic [cnt_w(L2_DEPTH)-1:0]  l2_word;
    logic                        l2_last;

    assign beat     = s_valid && s_ready;
    assign lut_last = (lut_cnt == LW'(LUT_DEPTH - 1));

    bank_word_counter #(
        .BANKS (L1_BANKS),
        .DEPTH (L1_DEPTH)
    ) u_l1_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (beat && !abort && state == L1),
        .clr   (abort),
        .bank  (l1_bank),
        .word  (l1_word),
        .last  (l1_last)
    );

    bank_word_counter #(
        .BANKS (L2_BANKS),
        .DEPTH (L2_DEPTH)
    ) u_l2_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (beat && !abort && state == L2),
        .clr   (abort),
        .bank  (l2_bank),
        .word  (l2_word),
        .last  (l2_last)
    );

    // Abort dominates everything, including a start seen while idle.
    always_comb begin
        // NOTE: default first so every path assigns nxt and no latch is inferred.
        nxt = state;
        if (abort) begin
            nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (start) nxt = next_phase(load_mask, IDLE);
                LUT_KEY: if (beat) nxt = LUT_VAL;
                LUT_VAL: if (beat) nxt = lut_last ? next_phase(mask_reg, LUT_VAL) : LUT_KEY;
                L1:      if (beat && l1_last) nxt = next_phase(mask_reg, L1);
                L2:      if (beat && l2_last) nxt = DONE;
                DONE:    nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end
    end

    // Status outputs are decoded from the next state so they change together with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mask_reg  <= '0;
            key_reg   <= '0;
            lut_cnt   <= '0;
            s_ready   <= 1'b0;
            en        <= 2'b00;
            we        <= '0;
            active_we <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= nxt;
            s_ready   <= (nxt == LUT_KEY) || (nxt == LUT_VAL) || (nxt == L1) || (nxt == L2);
            en        <= (nxt == L1) ? 2'b01 : (nxt == L2) ? 2'b10 : 2'b00;
            busy      <= (nxt != IDLE);
            done      <= (state == DONE) && !abort;
            we        <= '0;
            active_we <= 1'b0;

            if (state == IDLE && start && !abort)
                mask_reg <= load_mask;

            if (abort) begin
                key_reg <= '0;
                lut_cnt <= '0;
            end else if (beat) begin
                unique case (state)
                    LUT_KEY: key_reg <= s_data;
                    LUT_VAL: begin
                        active_we <= 1'b1;
                        addr      <= ADDR_W'(key_reg);
                        wdata     <= s_data;
                        lut_cnt   <= lut_last ? '0 : lut_cnt + 1'b1;
                    end
                    L1: begin
                        we    <= WE_ONE << l1_bank;
                        addr  <= ADDR_W'(l1_word);
                        wdata <= s_data;
                    end
                    L2: begin
                        we    <= WE_ONE << (L1_BANKS + int'(l2_bank));
                        addr  <= ADDR_W'(l2_word);
                        wdata <= s_data;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nn_param_loader.sv
// Self-checking bench: random and directed loads compared against a
// loop-based model of the expected write sequence.
module tb_nn_param_loader;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 18;
    localparam int LUT_DEPTH = 2;
    localparam int L1_BANKS  = 3;
    localparam int L1_DEPTH  = 2;
    localparam int L2_BANKS  = 2;
    localparam int L2_DEPTH  = 2;
    localparam int WE_W      = L1_BANKS + L2_BANKS;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [2:0]        load_mask = 3'b000;
    logic              abort = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] s_data = '0;
    logic [1:0]        en;
    logic [WE_W-1:0]   we;
    logic              active_we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] words[$];
    logic [47:0]       exp_q[$];
    logic [47:0]       obs_q[$];
    int                exp_beats, beats;
    int                done_cnt, en2_seen, lut_seen, hold_viol, strobe_viol;
    logic [ADDR_W-1:0] prev_addr;
    logic [DATA_W-1:0] prev_wdata;
    bit                have_prev = 1'b0;

    nn_param_loader #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .LUT_DEPTH (LUT_DEPTH),
        .L1_BANKS  (L1_BANKS),
        .L1_DEPTH  (L1_DEPTH),
        .L2_BANKS  (L2_BANKS),
        .L2_DEPTH  (L2_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .load_mask (load_mask),
        .abort     (abort),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .en        (en),
        .we        (we),
        .active_we (active_we),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [47:0] rec(input bit lut, input int bank,
                                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        return {5'b0, lut, 8'(bank), a, d};
    endfunction

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Monitor: record every write strobe and track protocol properties.
    always @(negedge clk) begin
        if (reset) begin
            if (active_we) begin
                obs_q.push_back(rec(1'b1, 0, addr, wdata));
                lut_seen++;
            end
            for (int b = 0; b < WE_W; b++)
                if (we[b]) obs_q.push_back(rec(1'b0, b, addr, wdata));
            if ($countones(we) + int'(active_we) > 1 || en == 2'b11) strobe_viol++;
            if (done) done_cnt++;
            if (en == 2'b10) en2_seen++;
            if (have_prev && !active_we && we == '0 && (addr != prev_addr || wdata != prev_wdata))
                hold_viol++;
            prev_addr  = addr;
            prev_wdata = wdata;
            have_prev  = 1'b1;
        end else begin
            have_prev = 1'b0;
        end
    end

    // Reference: consume the stream in phase order, one record per write.
    task automatic build_expected(input logic [2:0] mask);
        int p = 0;
        exp_q.delete();
        if (mask[0])
            for (int e = 0; e < LUT_DEPTH; e++) begin
                exp_q.push_back(rec(1'b1, 0, {2'b00, words[p]}, words[p+1]));
                p += 2;
            end
        if (mask[1])
            for (int b = 0; b < L1_BANKS; b++)
                for (int w = 0; w < L1_DEPTH; w++) begin
                    exp_q.push_back(rec(1'b0, b, ADDR_W'(w), words[p]));
                    p++;
                end
        if (mask[2])
            for (int b = 0; b < L2_BANKS; b++)
                for (int w = 0; w < L2_DEPTH; w++) begin
                    exp_q.push_back(rec(1'b0, L1_BANKS + b, ADDR_W'(w), words[p]));
                    p++;
                end
        exp_beats = p;
    endtask

    task automatic random_words();
        words.delete();
        for (int i = 0; i < 14; i++) words.push_back(DATA_W'($urandom));
    endtask

    // Stream the load. abort_at/start_at/rst_at are beat indices (-1 = never).
    task automatic run_load(input logic [2:0] mask, input bit gaps, input int abort_at,
                            input int start_at, input int rst_at);
        int idx = 0;
        bit acc, aborting = 1'b0;
        build_expected(mask);
        obs_q.delete();
        done_cnt = 0; en2_seen = 0; lut_seen = 0; hold_viol = 0; strobe_viol = 0; beats = 0;
        @(posedge clk); #1;
        start = 1'b1; load_mask = mask;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 200 && idx < exp_beats; cyc++) begin
            s_valid   = !gaps || (cyc % 2 == 0);
            s_data    = words[idx];
            abort     = (idx == abort_at) && s_valid;
            start     = (idx == start_at);
            load_mask = start ? ~mask : mask;
            acc       = s_valid && s_ready;
            aborting  = abort;
            @(posedge clk); #1;
            abort = 1'b0;
            start = 1'b0;
            if (aborting) break;
            if (acc) begin
                idx++;
                beats++;
            end
            if (idx == rst_at) begin
                #2 reset = 1'b0;
                #1 check("rst_async_outputs",
                         {s_ready, en, we, active_we, addr, wdata, busy, done}, 64'd0);
                break;
            end
        end
        s_valid = 1'b0;
        if (!aborting && reset) begin
            for (int c = 0; c < 10 && busy; c++) begin
                @(posedge clk); #1;
            end
            check("end_busy_low", busy, 1'b0);
            @(posedge clk); #1;
        end
    endtask

    task automatic compare_writes(input string tag, input int exp_done);
        check({tag, "_wr_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), obs_q[i], exp_q[i]);
        check({tag, "_done_count"}, done_cnt, exp_done);
        check({tag, "_strobe_onehot"}, strobe_viol, 0);
        check({tag, "_addr_hold"}, hold_viol, 0);
    endtask

    initial begin
        #7;
        check("reset_outputs", {s_ready, en, we, active_we, addr, wdata, busy, done}, 64'd0);
        #10 reset = 1'b1;

        // Full load with the directed word list.
        words = '{16'h0005, 16'h00AA, 16'h0007, 16'h00BB,
                  16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005,
                  16'h2000, 16'h2001, 16'h2002, 16'h2003};
        run_load(3'b111, 1'b0, -1, -1, -1);
        compare_writes("full", 1);
        check("full_beats", beats, 14);
        check("full_first_lut", obs_q.size() > 0 ? obs_q[0] : 48'd0, rec(1'b1, 0, 18'd5, 16'h00AA));
        check("full_en2_seen", en2_seen != 0, 1'b1);

        // Backpressure: s_valid toggles; same image, addr/wdata hold in gaps.
        run_load(3'b111, 1'b1, -1, -1, -1);
        compare_writes("bp", 1);
        check("bp_beats", beats, 14);

        // L1 only with random data.
        random_words();
        run_load(3'b010, 1'b0, -1, -1, -1);
        compare_writes("l1only", 1);
        check("l1only_no_lut", lut_seen, 0);
        check("l1only_no_en2", en2_seen, 0);

        // Empty mask: done two cycles after start, nothing written.
        obs_q.delete();
        done_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; load_mask = 3'b000;
        @(posedge clk); #1;
        start = 1'b0;
        check("m0_cycle1", {done, busy, s_ready}, 3'b010);
        @(posedge clk); #1;
        check("m0_cycle2", {done, busy}, 2'b10);
        @(posedge clk); #1;
        check("m0_cycle3", {done, busy}, 2'b00);
        check("m0_no_writes", obs_q.size(), 0);
        check("m0_done_count", done_cnt, 1);

        // Abort on the third L1 beat, then a clean restart.
        random_words();
        run_load(3'b010, 1'b0, 2, -1, -1);
        check("abort_busy_next", {busy, s_ready}, 2'b00);
        repeat (4) begin
            @(posedge clk); #1;
        end
        while (exp_q.size() > 2) void'(exp_q.pop_back());
        compare_writes("abort", 0);
        random_words();
        run_load(3'b010, 1'b0, -1, -1, -1);
        compare_writes("restart", 1);

        // start pulsed while busy must be ignored.
        random_words();
        run_load(3'b111, 1'b0, -1, 8, -1);
        compare_writes("busy_start", 1);
        check("busy_start_beats", beats, 14);

        // Asynchronous reset during L2, then a LUT-only load.
        random_words();
        run_load(3'b111, 1'b0, -1, -1, 11);
        @(posedge clk);
        #4 reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", {busy, s_ready, done}, 3'b000);
        random_words();
        run_load(3'b001, 1'b1, -1, -1, -1);
        compare_writes("lut_after_rst", 1);
        check("lut_after_rst_beats", beats, 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
